// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl_if
//  Description : Handshake and datapath bundle between the AES round
//                controller and its environment (input block, key schedule,
//                shared round datapath, output block).
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_ctrl_if #(
  parameter int NUM_ROUNDS = 10,
  parameter int RW         = $clog2(NUM_ROUNDS + 1)
);
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic          rk_req;
  logic [RW-1:0] rk_round;
  logic          rk_valid;
  logic [127:0]  rk_data;
  logic [127:0]  dp_state;
  logic          dp_final;
  logic [127:0]  dp_result;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_data;
  logic          busy;

  // Controller side.
  modport master (
    input  in_valid, in_data, rk_valid, rk_data, dp_result, out_ready,
    output in_ready, rk_req, rk_round, dp_state, dp_final, out_valid,
           out_data, busy
  );

  // Environment side.
  modport slave (
    output in_valid, in_data, rk_valid, rk_data, dp_result, out_ready,
    input  in_ready, rk_req, rk_round, dp_state, dp_final, out_valid,
           out_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_ctrl
//  Description : Iterative AES-128 encryption controller. Holds the 128-bit
//                state, performs the initial addRoundKey and then sequences
//                the shared round datapath plus an external key schedule for
//                NUM_ROUNDS rounds.
//  Options     : AES_CTRL_BACK2BACK_EN - accept the next block in the same
//                cycle the ciphertext is handed off (no idle bubble).
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input logic              clk,
  input logic              rst,
  aes_round_ctrl_if.master bus
);
  localparam int            RW           = $clog2(NUM_ROUNDS + 1);
  localparam logic [RW-1:0] C_LAST_ROUND = RW'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEY  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [127:0]  data_q,  data_d;
  logic [RW-1:0] round_q, round_d;

  logic w_in_ready;
  logic w_rk_req;
  logic w_out_valid;
  logic w_dp_final;

  // State, data and round registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      round_q <= round_d;
    end
  end

  // Next-state, data update and handshake outputs.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    round_d     = round_q;
    w_in_ready  = 1'b0;
    w_rk_req    = 1'b0;
    w_out_valid = 1'b0;
    w_dp_final  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          round_d = '0;
          state_d = ST_KEY;
        end
      end
      ST_KEY: begin
        w_rk_req   = 1'b1;
        w_dp_final = (round_q == C_LAST_ROUND);
        // A missing key simply stalls; nothing advances until rk_valid.
        if (bus.rk_valid) begin
          // Round 0 is the bare addRoundKey; later rounds go through the datapath.
          if (round_q == '0) begin
            data_d = data_q ^ bus.rk_data;
          end else begin
            data_d = bus.dp_result ^ bus.rk_data;
          end
          if (round_q == C_LAST_ROUND) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
`ifdef AES_CTRL_BACK2BACK_EN
        // Handing off the ciphertext frees the state register this very cycle.
        w_in_ready = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            data_d  = bus.in_data;
            round_d = '0;
            state_d = ST_KEY;
          end else begin
            state_d = ST_IDLE;
          end
        end
`else
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.rk_req    = w_rk_req;
  assign bus.rk_round  = round_q;
  assign bus.dp_state  = data_q;
  assign bus.dp_final  = w_dp_final;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = data_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_ctrl
//  Description : Self-checking bench for aes_round_ctrl. Supplies a real
//                AES key schedule and round datapath, compares against a
//                full-cipher reference and the FIPS-197 known answer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;
  localparam int NR = 10;

  localparam logic [127:0] C_FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst;

  aes_round_ctrl_if #(.NUM_ROUNDS(NR)) ifc ();
  aes_round_ctrl_if #(.NUM_ROUNDS(1))  ifc1 ();

  aes_round_ctrl #(.NUM_ROUNDS(NR)) dut  (.clk(clk), .rst(rst), .bus(ifc));
  aes_round_ctrl #(.NUM_ROUNDS(1))  dut1 (.clk(clk), .rst(rst), .bus(ifc1));

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [7:0]   sbox_t     [256];
  logic [127:0] rkeys      [16];
  int           stall_plan [16];
  int           stall_left [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] t;
    t = {a, a} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      sbox_t[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic fin);
    logic [7:0]   b [16];
    logic [7:0]   s [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) b[i] = sbox_t[st[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[c*4+r] = b[((c + r) % 4)*4 + r];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = s[c*4]; a1 = s[c*4+1]; a2 = s[c*4+2]; a3 = s[c*4+3];
        s[c*4]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        s[c*4+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        s[c*4+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        s[c*4+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic expand_key(input logic [127:0] key, input int nr);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= nr; r++) rkeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
    logic [127:0] s;
    s = pt ^ rkeys[0];
    for (int r = 1; r <= nr; r++) s = aes_round(s, r == nr) ^ rkeys[r];
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- environment drivers ----------------
  // Advance one cycle and present the datapath result for the new state.
  task automatic step();
    @(posedge clk);
    #1;
    ifc.dp_result  = aes_round(ifc.dp_state, ifc.dp_final);
    ifc1.dp_result = aes_round(ifc1.dp_state, ifc1.dp_final);
  endtask

  // Key schedule: honour planned stalls, send junk while not requested.
  task automatic drive_rk();
    if (ifc.rk_req) begin
      if (stall_left[ifc.rk_round] > 0) begin
        stall_left[ifc.rk_round]--;
        ifc.rk_valid = 1'b0;
        ifc.rk_data  = rand128();
      end else begin
        ifc.rk_valid = 1'b1;
        ifc.rk_data  = rkeys[ifc.rk_round];
      end
    end else begin
      ifc.rk_valid = 1'($urandom_range(0, 1));
      ifc.rk_data  = rand128();
    end
  endtask

  task automatic clear_stalls();
    for (int r = 0; r < 16; r++) begin
      stall_plan[r] = 0;
      stall_left[r] = 0;
    end
  endtask

  task automatic run_block(input logic [127:0] pt, input int bp, input bit has_kat,
                           input logic [127:0] kat);
    logic [127:0] exp_ct;
    int           exp_lat, k, er;
    bit           done;
    exp_ct  = aes_ref(pt, NR);
    exp_lat = NR + 2;
    for (int r = 0; r < 16; r++) begin
      stall_left[r] = stall_plan[r];
      if (r <= NR) exp_lat += stall_plan[r];
    end
    check_eq("idle_in_ready", 128'(ifc.in_ready), 128'(1));
    ifc.in_valid  = 1'b1;
    ifc.in_data   = pt;
    ifc.out_ready = 1'b0;
    drive_rk();
    k = 0; er = 0; done = 1'b0;
    while (!done && k <= exp_lat + 20) begin
      step();
      k++;
      if (ifc.out_valid) begin
        done = 1'b1;
      end else begin
        check_eq("rk_round", 128'(ifc.rk_round), 128'(er));
        check_eq("dp_final", 128'(ifc.dp_final), 128'(er == NR));
        check_eq("key_flags", 128'({ifc.in_ready, ifc.busy, ifc.rk_req}), 128'(3'b011));
        ifc.in_valid = 1'($urandom_range(0, 1));
        ifc.in_data  = rand128();
        drive_rk();
        if (ifc.rk_req && ifc.rk_valid) er++;
      end
    end
    check_eq("latency", 128'(k), 128'(exp_lat));
    if (!done) return;
    for (int i = 0; i < bp; i++) begin
      check_eq("bp_valid_busy", 128'({ifc.out_valid, ifc.busy}), 128'(2'b11));
      check_eq("bp_data", ifc.out_data, exp_ct);
      check_eq("bp_in_ready", 128'(ifc.in_ready), 128'(0));
      ifc.in_valid = 1'b1;
      ifc.in_data  = rand128();
      drive_rk();
      step();
    end
    check_eq("out_valid", 128'(ifc.out_valid), 128'(1));
    check_eq("out_data", ifc.out_data, exp_ct);
    if (has_kat) check_eq("out_kat", ifc.out_data, kat);
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    drive_rk();
    step();
    ifc.out_ready = 1'b0;
    check_eq("post_flags", 128'({ifc.in_ready, ifc.out_valid, ifc.busy}), 128'(3'b100));
  endtask

  task automatic reset_mid(input logic [127:0] pt);
    bit seen;
    clear_stalls();
    ifc.in_valid = 1'b1;
    ifc.in_data  = pt;
    drive_rk();
    step();
    ifc.in_valid = 1'b0;
    for (int i = 0; i < 30 && !(ifc.rk_req && ifc.rk_round == 4'd5); i++) begin
      drive_rk();
      step();
    end
    check_eq("mid_round", 128'(ifc.rk_round), 128'(5));
    rst = 1'b1;
    drive_rk();
    step();
    rst = 1'b0;
    check_eq("rst_flags", 128'({ifc.in_ready, ifc.out_valid, ifc.busy, ifc.rk_req}), 128'(4'b1000));
    check_eq("rst_state", ifc.dp_state, 128'(0));
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive_rk();
      step();
      if (ifc.out_valid) seen = 1'b1;
    end
    check_eq("rst_no_out", 128'(seen), 128'(0));
  endtask

  task automatic b2b(input logic [127:0] pa, input logic [127:0] pb);
    logic [127:0] exp_a, exp_b;
    int           t, ta, tb;
    bit           sent;
    clear_stalls();
    exp_a = aes_ref(pa, NR);
    exp_b = aes_ref(pb, NR);
    t = 0; ta = -1; tb = -1; sent = 1'b0;
    ifc.in_valid  = 1'b1;
    ifc.in_data   = pa;
    ifc.out_ready = 1'b1;
    drive_rk();
    while (tb < 0 && t < 4*NR + 20) begin
      step();
      t++;
      if (ifc.out_valid) begin
        if (ta < 0) begin
          ta = t;
          check_eq("b2b_a_data", ifc.out_data, exp_a);
        end else begin
          tb = t;
          check_eq("b2b_b_data", ifc.out_data, exp_b);
        end
      end
      ifc.in_valid = (ta >= 0) && !sent;
      ifc.in_data  = pb;
      drive_rk();
      #1;
      if (ifc.in_valid && ifc.in_ready) sent = 1'b1;
    end
    check_eq("b2b_t_a", 128'(ta), 128'(NR + 2));
`ifdef AES_CTRL_BACK2BACK_EN
    check_eq("b2b_t_b", 128'(tb), 128'(2*NR + 4));
`else
    check_eq("b2b_t_b", 128'(tb), 128'(2*NR + 5));
`endif
    ifc.in_valid = 1'b0;
    drive_rk();
    step();
    ifc.out_ready = 1'b0;
    check_eq("b2b_post", 128'({ifc.out_valid, ifc.busy}), 128'(2'b00));
  endtask

  // Single-round build: only keys 0 and 1, final round is round 1.
  task automatic nr1_test(input logic [127:0] pt);
    logic [127:0] exp_ct;
    int           k, er;
    bit           done;
    exp_ct = aes_ref(pt, 1);
    ifc1.in_valid  = 1'b1;
    ifc1.in_data   = pt;
    ifc1.out_ready = 1'b0;
    ifc1.rk_valid  = 1'b0;
    k = 0; er = 0; done = 1'b0;
    while (!done && k < 10) begin
      step();
      k++;
      ifc1.in_valid = 1'b0;
      if (ifc1.out_valid) begin
        done = 1'b1;
      end else begin
        check_eq("nr1_rk_round", 128'(ifc1.rk_round), 128'(er));
        check_eq("nr1_dp_final", 128'(ifc1.dp_final), 128'(er == 1));
        ifc1.rk_valid = 1'b1;
        ifc1.rk_data  = rkeys[ifc1.rk_round];
        er++;
      end
    end
    check_eq("nr1_latency", 128'(k), 128'(3));
    check_eq("nr1_data", ifc1.out_data, exp_ct);
    ifc1.rk_valid  = 1'b0;
    ifc1.out_ready = 1'b1;
    step();
    ifc1.out_ready = 1'b0;
    check_eq("nr1_post", 128'({ifc1.out_valid, ifc1.in_ready}), 128'(2'b01));
  endtask

  initial begin
    build_sbox();
    clear_stalls();
    rst = 1'b1;
    ifc.in_valid   = 1'b0; ifc.in_data   = '0; ifc.out_ready  = 1'b0;
    ifc.rk_valid   = 1'b0; ifc.rk_data   = '0; ifc.dp_result  = '0;
    ifc1.in_valid  = 1'b0; ifc1.in_data  = '0; ifc1.out_ready = 1'b0;
    ifc1.rk_valid  = 1'b0; ifc1.rk_data  = '0; ifc1.dp_result = '0;
    repeat (3) step();
    check_eq("reset_flags", 128'({ifc.in_ready, ifc.out_valid, ifc.rk_req, ifc.busy, ifc.dp_final}),
             128'(5'b10000));
    check_eq("reset_state", ifc.dp_state, 128'(0));
    check_eq("reset_round", 128'(ifc.rk_round), 128'(0));
    rst = 1'b0;

    expand_key(C_FIPS_KEY, NR);
    run_block(C_FIPS_PT, 0, 1'b1, C_FIPS_CT);

    stall_plan[0] = 3;
    stall_plan[7] = 2;
    run_block(C_FIPS_PT, 0, 1'b1, C_FIPS_CT);
    clear_stalls();

    run_block(C_FIPS_PT, 5, 1'b1, C_FIPS_CT);

    reset_mid(C_FIPS_PT);
    run_block(C_FIPS_PT, 0, 1'b1, C_FIPS_CT);

    b2b(C_FIPS_PT, rand128());
    nr1_test(rand128());

    for (int n = 0; n < 12; n++) begin
      expand_key(rand128(), NR);
      for (int r = 0; r < 16; r++)
        stall_plan[r] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_block(rand128(), int'($urandom_range(0, 3)), 1'b0, 128'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
